ram_arbiter: RTL and testbench

Four-port arbiter that shares the single RAM port between the two cores' instruction and data requests. It sits between the per-core cache request lines and the RAM model. Each transaction is held until RAM reports ACCESS. Policy: data over instruction, round-robin between cores within a class, and a starvation limit that forces an instruction grant.

---
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port between the D and I request lines
// of two cores. Data requests beat instruction requests, the cores take turns
// within a class, and an instruction request that has waited too long behind
// data grants forces the next arbitration to pick the I class.

package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// Handshake: a port raises req_ren/req_wen (its "valid") and holds it, with
// stable address/data, until the one cycle in which its req_wait is low (its
// "ready"); that cycle is the completion. Dropping both strobes before then
// abandons the request without a completion.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [3:0]       req_ren,
  input  logic [3:0]       req_wen,
  input  logic [3:0][31:0] req_addr,
  input  logic [3:0][31:0] req_store,
  output logic [3:0]       req_wait,
  output logic [31:0]      req_load,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate,
  output logic [3:0]       grant,
  output logic             ram_err,
  output logic             dbg_state,
  output logic [3:0]       dbg_starve_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last_core;   // bit 0: D class, bit 1: I class
  logic [3:0] starve_cnt;

  logic [3:0] act;
  logic [1:0] g_idx;
  logic       g_act;
  logic       pick_i;
  logic [1:0] cls_act;
  logic       win_core;
  logic [3:0] win;

  assign act            = req_ren | req_wen;
  assign g_act          = act[g_idx];
  assign req_load       = ramload;
  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // Encode the one-hot grant into the port index that drives the RAM.
  always_comb begin
    g_idx = 2'd0;
    case (grant)
      4'b0010: g_idx = 2'd1;
      4'b0100: g_idx = 2'd2;
      4'b1000: g_idx = 2'd3;
      default: g_idx = 2'd0;
    endcase
  end

  // Pick the class, then the core within it; only consumed in IDLE.
  always_comb begin
    pick_i = 1'b0;
    if (|act[3:2] && (int'(starve_cnt) >= STARVE_LIMIT))
      pick_i = 1'b1;
    else if (!(|act[1:0]))
      pick_i = 1'b1;
    cls_act = pick_i ? act[3:2] : act[1:0];
    if (&cls_act)
      win_core = ~last_core[pick_i];
    else
      win_core = cls_act[1];
    win = 4'b0001 << {pick_i, win_core};
  end

  // Arbitration state: grant, round-robin history and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      last_core  <= 2'b00;
      starve_cnt <= 4'd0;
    end else begin
      // grant is nonzero only in XFER, so this never meets the clear below
      if ((|grant[1:0]) && (|act[3:2]) && (starve_cnt != 4'hF))
        starve_cnt <= starve_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (|act) begin
            state               <= XFER;
            grant               <= win;
            last_core[pick_i]   <= win_core;
            if (pick_i)
              starve_cnt <= 4'd0;
          end
        end
        XFER: begin
          // ACCESS wins over a simultaneous abort: both end the transfer
          if ((ramstate == ACCESS) || !g_act) begin
            state <= IDLE;
            grant <= 4'b0000;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

  // RAM drive and per-port wait; everything idle outside XFER.
  always_comb begin
    req_wait = 4'b1111;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    ram_err  = 1'b0;
    if (state == XFER) begin
      ramWEN = req_wen[g_idx];
      ramREN = req_ren[g_idx] & ~req_wen[g_idx];
      if (g_act) begin
        ramaddr  = req_addr[g_idx];
        ramstore = req_store[g_idx];
      end
      if (ramstate == ACCESS)
        req_wait[g_idx] = 1'b0;
      ram_err = (ramstate == ERROR) && g_act;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: the bench plays both the requesting cores
// and the RAM, deciding ramstate each cycle.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic             CLK;
  logic             nRST;
  logic [3:0]       req_ren;
  logic [3:0]       req_wen;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_store;
  logic [3:0]       req_wait;
  logic [31:0]      req_load;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  ramstate_t        ramstate;
  logic [3:0]       grant;
  logic             ram_err;
  logic             dbg_state;
  logic [3:0]       dbg_starve_cnt;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .ram_err(ram_err),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: inputs change at the falling edge, outputs checked 1ns later.
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req_ren = 4'b0001; req_wen = 4'b0000;
    req_addr = '0; req_store = '0;
    ramload = 32'd0; ramstate = FREE;
    cyc(); cyc(); #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant: got %b want 0000", grant); end
    checks++; if (req_wait !== 4'b1111) begin failures++; $display("FAIL rst_wait: got %b want 1111", req_wait); end
    checks++; if ({ramREN, ramWEN, ram_err} !== 3'b000) begin failures++; $display("FAIL rst_strobes: got %b want 000", {ramREN, ramWEN, ram_err}); end
    checks++; if ({ramaddr, ramstore} !== 64'd0) begin failures++; $display("FAIL rst_bus: got %h want 0", {ramaddr, ramstore}); end
    checks++; if ({dbg_state, dbg_starve_cnt} !== 5'd0) begin failures++; $display("FAIL rst_dbg: got %b want 00000", {dbg_state, dbg_starve_cnt}); end
    cyc(); nRST = 1'b1; req_ren = 4'b0000;
  endtask

  task automatic test_single_read();
    cyc(); req_ren = 4'b0001; req_addr[0] = 32'h40; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rd_req_cycle_grant: got %b want 0000", grant); end
    cyc(); ramstate = BUSY; #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rd_grant: got %b want 0001", grant); end
    checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin failures++; $display("FAIL rd_drive: got %b %b %h want 1 0 00000040", ramREN, ramWEN, ramaddr); end
    checks++; if (req_wait !== 4'b1111) begin failures++; $display("FAIL rd_wait_busy: got %b want 1111", req_wait); end
    cyc(); #1;
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    checks++; if (req_wait !== 4'b1110) begin failures++; $display("FAIL rd_wait_access: got %b want 1110", req_wait); end
    checks++; if (req_load !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_load: got %h want deadbeef", req_load); end
    cyc(); req_ren = 4'b0000; ramstate = FREE; #1;
    checks++; if (grant !== 4'b0000 || req_wait !== 4'b1111) begin failures++; $display("FAIL rd_back_idle: got grant %b wait %b want 0000 1111", grant, req_wait); end
  endtask

  task automatic test_error_write();
    // both strobes high on port 1: must be treated as a write
    cyc(); req_ren = 4'b0010; req_wen = 4'b0010;
    req_addr[1] = 32'h80; req_store[1] = 32'h12345678; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL wr_req_cycle_grant: got %b want 0000", grant); end
    for (int k = 0; k < 2; k++) begin
      cyc(); ramstate = ERROR; #1;
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL wr_grant_%0d: got %b want 0010", k, grant); end
      checks++; if ({ramREN, ramWEN, ram_err} !== 3'b011) begin failures++; $display("FAIL wr_err_strobes_%0d: got %b want 011", k, {ramREN, ramWEN, ram_err}); end
      checks++; if (ramaddr !== 32'h80 || ramstore !== 32'h12345678) begin failures++; $display("FAIL wr_bus_%0d: got %h %h want 00000080 12345678", k, ramaddr, ramstore); end
      checks++; if (req_wait !== 4'b1111) begin failures++; $display("FAIL wr_wait_err_%0d: got %b want 1111", k, req_wait); end
    end
    cyc(); ramstate = ACCESS; #1;
    checks++; if ({ramWEN, ram_err, req_wait} !== 6'b10_1101) begin failures++; $display("FAIL wr_access: got wen %b err %b wait %b want 1 0 1101", ramWEN, ram_err, req_wait); end
    checks++; if (ramstore !== 32'h12345678) begin failures++; $display("FAIL wr_store_access: got %h want 12345678", ramstore); end
    cyc(); req_ren = 4'b0000; req_wen = 4'b0000; ramstate = FREE; #1;
    checks++; if (grant !== 4'b0000 || ram_err !== 1'b0) begin failures++; $display("FAIL wr_back_idle: got grant %b err %b want 0000 0", grant, ram_err); end
  endtask

  task automatic test_back_to_back();
    // last D winner so far is core1, so core0 goes first
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 4'b0001 : 4'b0010);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] exp_g;
      cyc(); req_ren = 4'b0011; ramstate = FREE; #1;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL b2b_turnaround_%0d: got %b want 0000", k, grant); end
      cyc(); ramstate = ACCESS; #1;
      exp_g = exp_q.pop_front();
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL b2b_grant_%0d: got %b want %b", k, grant, exp_g); end
      checks++; if (req_wait !== ~exp_g) begin failures++; $display("FAIL b2b_wait_%0d: got %b want %b", k, req_wait, ~exp_g); end
    end
    cyc(); req_ren = 4'b0000; ramstate = FREE; #1;
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 8; k++) begin
      cyc(); req_ren = 4'b0111; ramstate = FREE; #1;
      checks++; if (grant !== 4'b0000 || dbg_starve_cnt !== 4'(k)) begin failures++; $display("FAIL stv_idle_%0d: got grant %b cnt %0d want 0000 %0d", k, grant, dbg_starve_cnt, k); end
      cyc(); ramstate = ACCESS; #1;
      checks++; if (grant !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin failures++; $display("FAIL stv_dgrant_%0d: got %b want %b", k, grant, (k % 2 == 0) ? 4'b0001 : 4'b0010); end
    end
    cyc(); ramstate = FREE; #1;
    checks++; if (dbg_starve_cnt !== 4'd8) begin failures++; $display("FAIL stv_cnt_limit: got %0d want 8", dbg_starve_cnt); end
    cyc(); ramstate = ACCESS; #1;
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stv_igrant: got %b want 0100", grant); end
    checks++; if (dbg_starve_cnt !== 4'd0) begin failures++; $display("FAIL stv_cnt_clear: got %0d want 0", dbg_starve_cnt); end
    checks++; if (req_wait !== 4'b1011) begin failures++; $display("FAIL stv_iwait: got %b want 1011", req_wait); end
    cyc(); req_ren = 4'b0000; ramstate = FREE; #1;
  endtask

  task automatic test_abort();
    cyc(); req_ren = 4'b1001; req_addr[0] = 32'h44; req_addr[3] = 32'h300; #1;
    cyc(); ramstate = BUSY; #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL abt_grant: got %b want 0001", grant); end
    cyc(); req_ren = 4'b1000; #1;
    checks++; if (req_wait !== 4'b1111 || ramREN !== 1'b0 || ramaddr !== 32'd0) begin failures++; $display("FAIL abt_drop: got wait %b ren %b addr %h want 1111 0 0", req_wait, ramREN, ramaddr); end
    cyc(); #1;
    checks++; if (grant !== 4'b0000 || req_wait !== 4'b1111) begin failures++; $display("FAIL abt_idle: got grant %b wait %b want 0000 1111", grant, req_wait); end
    cyc(); ramstate = ACCESS; #1;
    checks++; if (grant !== 4'b1000 || ramaddr !== 32'h300) begin failures++; $display("FAIL abt_port3: got grant %b addr %h want 1000 00000300", grant, ramaddr); end
    checks++; if (req_wait !== 4'b0111) begin failures++; $display("FAIL abt_port3_wait: got %b want 0111", req_wait); end
    cyc(); req_ren = 4'b0000; ramstate = FREE; #1;
  endtask

  task automatic test_reset_mid_xfer();
    cyc(); req_ren = 4'b0001; req_addr[0] = 32'h100; #1;
    cyc(); ramstate = BUSY; #1;
    checks++; if (grant !== 4'b0001 || ramREN !== 1'b1) begin failures++; $display("FAIL mrst_pre: got grant %b ren %b want 0001 1", grant, ramREN); end
    cyc(); nRST = 1'b0; #1;
    checks++; if (grant !== 4'b0000 || {ramREN, ramWEN} !== 2'b00 || req_wait !== 4'b1111) begin failures++; $display("FAIL mrst_low: got grant %b strobes %b wait %b want 0000 00 1111", grant, {ramREN, ramWEN}, req_wait); end
    cyc(); #1;
    checks++; if (grant !== 4'b0000 || ramaddr !== 32'd0) begin failures++; $display("FAIL mrst_hold: got grant %b addr %h want 0000 0", grant, ramaddr); end
    cyc(); nRST = 1'b1; ramstate = FREE; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mrst_release: got %b want 0000", grant); end
    cyc(); ramstate = ACCESS; #1;
    checks++; if (grant !== 4'b0001 || ramaddr !== 32'h100 || req_wait !== 4'b1110) begin failures++; $display("FAIL mrst_regrant: got grant %b addr %h wait %b want 0001 00000100 1110", grant, ramaddr, req_wait); end
    cyc(); req_ren = 4'b0000; ramstate = FREE; #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL mrst_end: got %b want 0000", grant); end
  endtask

  // Scenario sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_error_write();
    test_back_to_back();
    test_starvation();
    test_abort();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
